// File: rtl/fp_pkg.sv
// Shared FP32 field definitions and constant patterns for the divider and multiplier.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 24;

    localparam logic [7:0]  EXP_BIAS    = 8'd127;
    localparam logic [7:0]  EXP_ONES    = 8'hFF;
    localparam logic [7:0]  EXP_ZERO    = 8'h00;
    localparam logic [30:0] INF_MAG     = {8'hFF, 23'h000000};
    localparam logic [30:0] ZERO_MAG    = 31'h00000000;
    localparam logic [31:0] NAN_DEFAULT = 32'h7F800001;

    function automatic logic [31:0] pack_fp(input logic sign, input logic [EXP_W-1:0] exp,
                                            input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction
endpackage

// File: rtl/fp_classify.sv
// Classifies one FP32 operand; subnormals are reported as zero (flush-to-zero).
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] value,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero
);
    logic [EXP_W-1:0]  exp_s;
    logic [FRAC_W-1:0] frac_s;

    assign exp_s   = value[30:23];
    assign frac_s  = value[22:0];
    assign is_nan  = (exp_s == EXP_ONES) && (frac_s != 23'h000000);
    assign is_inf  = (exp_s == EXP_ONES) && (frac_s == 23'h000000);
    assign is_zero = (exp_s == EXP_ZERO);
endmodule

// File: rtl/fdiv_seq.sv
// Sequential FP32 divider (restoring, one quotient bit per cycle).
// Define FDIV_SEQ_ROUND_EN for round-to-nearest-even; default build truncates.
module fdiv_seq
    import fp_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = NAN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);
    typedef enum logic [2:0] {IDLE, CHECK, CALC, NORM, DONE} state_t;

    state_t              state_r;
    logic [31:0]         a_r, b_r;
    logic [24:0]         rem_r;
    logic [25:0]         q_r;
    logic [4:0]          cnt_r;

    logic                a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_inf_s, b_zero_s;
    logic                sign_s, special_s;
    logic [31:0]         special_out_s, norm_out_s;
    logic [24:0]         rem_in_s, rem_nxt_s;
    logic [25:0]         q_in_s, q_nxt_s, diff_s;
    logic [MANT_W-1:0]   ma_s, mb_s;
    logic [FRAC_W-1:0]   mant_s, mant_rnd_s;
    logic                guard_s, sticky_s, carry_s;
    logic signed [9:0]   exp_s, exp_rnd_s;

    fp_classify u_cls_a (.value(a_r), .is_nan(a_nan_s), .is_inf(a_inf_s), .is_zero(a_zero_s));
    fp_classify u_cls_b (.value(b_r), .is_nan(b_nan_s), .is_inf(b_inf_s), .is_zero(b_zero_s));

    assign sign_s = a_r[31] ^ b_r[31];
    assign ma_s   = {1'b1, a_r[22:0]};
    assign mb_s   = {1'b1, b_r[22:0]};

    // Special-operand result selection, evaluated while in CHECK
    always_comb begin
        special_s     = 1'b1;
        special_out_s = 32'h00000000;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            special_out_s = {1'b0, NAN_VALUE[30:0]};
        end else if (a_inf_s || b_zero_s) begin
            special_out_s = {sign_s, INF_MAG};
        end else if (a_zero_s || b_inf_s) begin
            special_out_s = {sign_s, ZERO_MAG};
        end else begin
            special_s     = 1'b0;
            special_out_s = 32'h00000000;
        end
    end

    // One restoring-division step; the first step runs on the CHECK exit edge
    always_comb begin
        if (state_r == CHECK) begin
            rem_in_s = {1'b0, ma_s};
            q_in_s   = 26'h0000000;
        end else begin
            rem_in_s = rem_r;
            q_in_s   = q_r;
        end
        diff_s = {1'b0, rem_in_s} - {2'b00, mb_s};
        if (diff_s[25]) begin
            rem_nxt_s = {rem_in_s[23:0], 1'b0};
            q_nxt_s   = {q_in_s[24:0], 1'b0};
        end else begin
            rem_nxt_s = {diff_s[23:0], 1'b0};
            q_nxt_s   = {q_in_s[24:0], 1'b1};
        end
    end

    // Normalise the quotient, round or truncate, then clamp the exponent
    always_comb begin
        if (q_r[25]) begin
            mant_s   = q_r[24:2];
            guard_s  = q_r[1];
            sticky_s = q_r[0] | (rem_r != 25'h0000000);
            exp_s    = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd127;
        end else begin
            mant_s   = q_r[23:1];
            guard_s  = q_r[0];
            sticky_s = (rem_r != 25'h0000000);
            exp_s    = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]}) + 10'sd126;
        end
`ifdef FDIV_SEQ_ROUND_EN
        {carry_s, mant_rnd_s} = {1'b0, mant_s} + {23'h000000, guard_s & (sticky_s | mant_s[0])};
`else
        carry_s    = 1'b0;
        mant_rnd_s = mant_s;
`endif
        exp_rnd_s = exp_s + (carry_s ? 10'sd1 : 10'sd0);
        if (exp_rnd_s >= 10'sd255) begin
            norm_out_s = {sign_s, INF_MAG};
        end else if (exp_rnd_s <= 10'sd0) begin
            norm_out_s = {sign_s, ZERO_MAG};
        end else begin
            norm_out_s = pack_fp(sign_s, exp_rnd_s[7:0], mant_rnd_s);
        end
    end

    // Control FSM with registered busy/done/out
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= 32'h00000000;
            cnt_r   <= 5'd0;
            a_r     <= 32'h00000000;
            b_r     <= 32'h00000000;
            q_r     <= 26'h0000000;
            rem_r   <= 25'h0000000;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        busy    <= 1'b1;
                        state_r <= CHECK;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CHECK: begin
                    if (special_s) begin
                        out     <= special_out_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        q_r     <= q_nxt_s;
                        rem_r   <= rem_nxt_s;
                        cnt_r   <= 5'd1;
                        state_r <= CALC;
                    end
                end
                CALC: begin
                    q_r   <= q_nxt_s;
                    rem_r <= rem_nxt_s;
                    if (cnt_r == 5'd25) begin
                        cnt_r   <= 5'd0;
                        state_r <= NORM;
                    end else begin
                        cnt_r   <= cnt_r + 5'd1;
                    end
                end
                NORM: begin
                    out     <= norm_out_s;
                    done    <= 1'b1;
                    state_r <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    cnt_r   <= 5'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed corner cases, reset behaviour and random operands
// compared against an arithmetic reference model.
module tb_fdiv_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    fdiv_seq dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                  .busy(busy), .done(done), .out(out));

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: quotient from plain integer division, then the normalisation rules.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y, output int lat);
        int ex, ey, e;
        longint unsigned ma, mb, q, r;
        logic [22:0] m;
        bit g, st, nx, ny, ix, iy, zx, zy;
        logic s;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 23'h0);
        ny = (ey == 255) && (y[22:0] != 23'h0);
        ix = (ex == 255) && (x[22:0] == 23'h0);
        iy = (ey == 255) && (y[22:0] == 23'h0);
        zx = (ex == 0);
        zy = (ey == 0);
        s = x[31] ^ y[31];
        lat = 2;
        if (nx || ny || (zx && zy) || (ix && iy)) return 32'h7F800001;
        if (ix || zy) return {s, 8'hFF, 23'h0};
        if (zx || iy) return {s, 31'h0};
        lat = 28;
        ma = {40'h0, 1'b1, x[22:0]};
        mb = {40'h0, 1'b1, y[22:0]};
        q = (ma << 25) / mb;
        r = (ma << 25) % mb;
        if (q >= (64'd1 << 25)) begin
            m = q[24:2]; g = q[1]; st = q[0] || (r != 0); e = ex - ey + 127;
        end else begin
            m = q[23:1]; g = q[0]; st = (r != 0); e = ex - ey + 126;
        end
`ifdef FDIV_SEQ_ROUND_EN
        if (g && (st || m[0])) begin
            if (m == 23'h7FFFFF) begin
                m = 23'h0;
                e = e + 1;
            end else begin
                m = m + 23'd1;
            end
        end
`endif
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], m};
    endfunction

    // Run one division; poke>0 pulses a stray start with other operands at that cycle.
    task automatic do_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_v, input int exp_lat, input int poke);
        int cyc;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'h0; b = 32'h0;
        cyc = 1;
        chk_eq({tag, ".busy_on"}, {31'h0, busy}, 32'h1);
        while (!done && cyc < 60) begin
            start = (cyc == poke);
            if (cyc == poke) begin
                a = 32'h3F800000; b = 32'h40400000;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk_eq({tag, ".lat"}, cyc, exp_lat);
        chk_eq({tag, ".out"}, out, exp_v);
        @(posedge clk); #1;
        chk_eq({tag, ".done_drop"}, {30'h0, busy, done}, 32'h0);
        chk_eq({tag, ".out_hold"}, out, exp_v);
    endtask

    localparam int ND = 7;
    logic [31:0] d_a   [ND] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                                32'h7F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] d_b   [ND] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                                32'h7F800000, 32'h3E800000, 32'h40000000};
`ifdef FDIV_SEQ_ROUND_EN
    logic [31:0] d_exp [ND] = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h7F800001,
                                32'h7F800001, 32'h7F800000, 32'h00000000};
`else
    logic [31:0] d_exp [ND] = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h7F800001,
                                32'h7F800001, 32'h7F800000, 32'h00000000};
`endif
    int d_lat [ND] = '{28, 28, 2, 2, 2, 28, 28};

    initial begin
        int lat, done_seen;
        logic [31:0] x, y, e;
        rst = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("reset.busy", {31'h0, busy}, 32'h0);
        chk_eq("reset.done", {31'h0, done}, 32'h0);
        chk_eq("reset.out", out, 32'h0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < ND; i++) do_div($sformatf("dir%0d", i), d_a[i], d_b[i], d_exp[i], d_lat[i], 0);

        // stray start during CALC must not change the result
        do_div("start_in_calc", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 5);

        // reset at CALC iteration 10 aborts with no done pulse
        @(negedge clk); a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_eq("abort.busy", {31'h0, busy}, 32'h0);
        chk_eq("abort.out", out, 32'h0);
        @(negedge clk); rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk_eq("abort.no_done", done_seen, 0);

        // reset dominates a simultaneous start
        @(negedge clk); rst = 1'b1; start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
        @(posedge clk); #1;
        chk_eq("rst_start.busy", {31'h0, busy}, 32'h0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk_eq("rst_start.idle", {30'h0, busy, done}, 32'h0);

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: x[30:23] = 8'h00;
                1: y[30:23] = 8'hFF;
                2: y[30:23] = 8'h00;
                3: begin x[30:23] = 8'hFF; x[22:0] = ($urandom_range(0, 1) == 0) ? 23'h0 : x[22:0]; end
                default: begin
                    x[30:23] = 8'(100 + $urandom_range(0, 60));
                    y[30:23] = 8'(100 + $urandom_range(0, 60));
                end
            endcase
            e = ref_div(x, y, lat);
            do_div($sformatf("rnd%0d", i), x, y, e, lat, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
